// File: rtl/sha_mem_port_arbiter.sv
// Burst arbiter sharing one 1-cycle-latency SRAM port between NUM_REQ requesters.
// Define SHA_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module sha_mem_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic                          mem_enable,
    output logic                          mem_write,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          burst_trunc
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic {ARB, BURST} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        gnt_idx;
    logic [CNT_W-1:0]        beat_cnt;
    logic [DATA_WIDTH-1:0]   rsp_hold;
    logic [IDX_W-1:0]        winner;
    logic                    in_burst;
    logic                    beat;
    logic [ADDR_WIDTH-1:0]   addr_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_a [NUM_REQ];

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        next_idx = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef SHA_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    // First requester at or after the pointer, searching cyclically.
    function automatic logic [IDX_W-1:0] pick_rr(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] c;
        pick_rr = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = IDX_W'((int'(p) + k) % NUM_REQ);
            if (r[c]) pick_rr = c;
        end
    endfunction

    assign winner = pick_rr(req, rr_ptr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (state == ARB && |req) begin
            rr_ptr <= next_idx(winner);
        end
    end
`else
    function automatic logic [IDX_W-1:0] pick_fixed(input logic [NUM_REQ-1:0] r);
        pick_fixed = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r[i]) pick_fixed = IDX_W'(i);
        end
    endfunction

    assign winner = pick_fixed(req);
`endif

    // Memory port is a pure mux of the granted requester; idle port drives zeros.
    assign in_burst = (state == BURST);
    assign beat     = in_burst & req[gnt_idx];

    always_comb begin
        mem_enable  = beat;
        mem_write   = beat & req_write[gnt_idx];
        mem_address = in_burst ? addr_a[gnt_idx]  : '0;
        mem_wdata   = in_burst ? wdata_a[gnt_idx] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ARB;
            gnt         <= '0;
            gnt_idx     <= '0;
            beat_cnt    <= '0;
            burst_trunc <= 1'b0;
            rsp_valid   <= '0;
        end else begin
            burst_trunc <= 1'b0;
            rsp_valid   <= (beat && !req_write[gnt_idx]) ? onehot(gnt_idx) : '0;
            case (state)
                ARB: begin
                    if (|req) begin
                        gnt      <= onehot(winner);
                        gnt_idx  <= winner;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (!req[gnt_idx] || req_last[gnt_idx]) begin
                        gnt   <= '0;
                        state <= ARB;
                    end else if (beat_cnt == CNT_MAX) begin
                        gnt         <= '0;
                        burst_trunc <= 1'b1;
                        state       <= ARB;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Read data passes straight through in the return cycle and is held afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_hold <= '0;
        end else if (|rsp_valid) begin
            rsp_hold <= mem_rdata;
        end
    end

    assign rsp_data = (|rsp_valid) ? mem_rdata : rsp_hold;

endmodule

// File: tb/tb_sha_mem_port_arbiter.sv
// Randomized bench for sha_mem_port_arbiter against a transaction-level reference model.
// Honors SHA_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_sha_mem_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int N_CYC = 4000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [AW-1:0]     mem_address;
    logic              mem_enable;
    logic              mem_write;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              burst_trunc;

    sha_mem_port_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_last(req_last), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .mem_address(mem_address), .mem_enable(mem_enable),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .burst_trunc(burst_trunc)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        init_val = 32'h428A2F98 ^ (DW'(a) * 32'h9E3779B9);
    endfunction

    // Single-port SRAM with 1-cycle read latency; refilled while reset is held.
    logic [DW-1:0] sram [1<<AW];
    always @(posedge clk) begin
        if (!reset) begin
            for (int a = 0; a < (1 << AW); a++) sram[a] <= init_val(a);
        end else if (mem_enable) begin
            if (mem_write) sram[mem_address] <= mem_wdata;
            else           mem_rdata <= sram[mem_address];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] ref_mem [1<<AW];
    int            owner;
    int            beats;
    int            ptr;
    bit            exp_trunc;
    bit            pend;
    int            pend_tag;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] hold;
    int            rem [NR];

    task automatic model_reset();
        owner = -1; beats = 0; ptr = 0; exp_trunc = 0;
        pend = 0; pend_tag = 0; pend_data = '0; hold = '0;
        for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_val(a);
    endtask

    task automatic check_all_zero(input string pfx);
        check_val({pfx, "_gnt"}, DW'(gnt), '0);
        check_val({pfx, "_rsp_valid"}, DW'(rsp_valid), '0);
        check_val({pfx, "_rsp_data"}, rsp_data, '0);
        check_val({pfx, "_burst_trunc"}, DW'(burst_trunc), '0);
        check_val({pfx, "_mem_enable"}, DW'(mem_enable), '0);
        check_val({pfx, "_mem_write"}, DW'(mem_write), '0);
        check_val({pfx, "_mem_address"}, DW'(mem_address), '0);
        check_val({pfx, "_mem_wdata"}, mem_wdata, '0);
    endtask

    function automatic int pick_winner(input logic [NR-1:0] r, input int p);
        pick_winner = -1;
`ifdef SHA_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NR; k++) begin
            if (pick_winner < 0 && r[(p + k) % NR]) pick_winner = (p + k) % NR;
        end
`else
        for (int i = 0; i < NR; i++) begin
            if (pick_winner < 0 && r[i]) pick_winner = i;
        end
`endif
    endfunction

    initial begin
        bit do_rst;
        bit rst_done;
        int cur;
        int a;
        logic [NR-1:0]  exp_gnt;
        logic [NR-1:0]  exp_rv;
        bit             beat;

        do_rst = 0; rst_done = 0;
        for (int i = 0; i < NR; i++) rem[i] = 0;
        model_reset();

        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);

            // Asynchronous reset the cycle after a read beat: response must vanish.
            if (do_rst) begin
                reset = 1'b0;
                #1;
                check_all_zero("midrst");
                repeat (2) @(negedge clk);
                model_reset();
                reset = 1'b1;
                do_rst = 0;
                rst_done = 1;
            end

            for (int i = 0; i < NR; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 24);
                req[i]       = (rem[i] > 0) && ($urandom_range(0, 19) != 0);
                req_last[i]  = (rem[i] == 1);
                req_write[i] = ($urandom_range(0, 2) == 0);
                req_addr[i*AW +: AW]  = AW'($urandom);
                req_wdata[i*DW +: DW] = DW'($urandom);
            end
            #1;

            exp_gnt = (owner >= 0) ? NR'(1 << owner) : '0;
            beat    = (owner >= 0) && req[owner];
            exp_rv  = pend ? NR'(1 << pend_tag) : '0;
            check_val("gnt", DW'(gnt), DW'(exp_gnt));
            check_val("mem_enable", DW'(mem_enable), DW'(beat));
            check_val("mem_write", DW'(mem_write), DW'(beat && req_write[owner]));
            if (beat) begin
                check_val("mem_address", DW'(mem_address), DW'(req_addr[owner*AW +: AW]));
                if (req_write[owner]) check_val("mem_wdata", mem_wdata, req_wdata[owner*DW +: DW]);
            end
            check_val("rsp_valid", DW'(rsp_valid), DW'(exp_rv));
            check_val("rsp_data", rsp_data, pend ? pend_data : hold);
            check_val("burst_trunc", DW'(burst_trunc), DW'(exp_trunc));

            // Advance the model across the coming rising edge.
            if (pend) hold = pend_data;
            pend = 0;
            exp_trunc = 0;
            cur = owner;
            if (cur < 0) begin
                if (|req) begin
                    owner = pick_winner(req, ptr);
                    beats = 0;
`ifdef SHA_ARB_ROUND_ROBIN_EN
                    ptr = (owner + 1) % NR;
`endif
                end
            end else if (!req[cur]) begin
                owner = -1;
            end else begin
                a = int'(req_addr[cur*AW +: AW]);
                if (req_write[cur]) begin
                    ref_mem[a] = req_wdata[cur*DW +: DW];
                end else begin
                    pend = 1; pend_tag = cur; pend_data = ref_mem[a];
                end
                if (rem[cur] > 0) rem[cur]--;
                beats++;
                if (req_last[cur]) begin
                    owner = -1;
                end else if (beats == MB) begin
                    exp_trunc = 1;
                    owner = -1;
                end
            end

            if (!rst_done && cyc > N_CYC / 2 && pend) do_rst = 1;
        end

        @(negedge clk);
        check_val("mid_reset_taken", DW'(rst_done), 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
